// File: rtl/rf_ctrl_pkg.sv
// Shared constants and types for the register-file writeback scheduler.
package rf_ctrl_pkg;
   localparam int ADDR_W = 3;
   localparam int DATA_W = 16;
   localparam int NREG   = 2 ** ADDR_W;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_MEM = 1'b1
   } src_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: bit 0 = ALU, bit 1 = MEM.
// The fairness pointer only moves on a tie, so a lone requester never steals the next tie.
module rr_arb2
   import rf_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   src_e rr_last_q, rr_last_d;

   always_comb begin
      gnt_o     = 2'b00;
      rr_last_d = rr_last_q;
      unique case (req_i)
         2'b01: gnt_o = 2'b01;
         2'b10: gnt_o = 2'b10;
         2'b11: begin
            if (rr_last_q == SRC_ALU) begin
               gnt_o     = 2'b10;
               rr_last_d = SRC_MEM;
            end else begin
               gnt_o     = 2'b01;
               rr_last_d = SRC_ALU;
            end
         end
         default: gnt_o = 2'b00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) rr_last_q <= SRC_ALU;
      else       rr_last_q <= rr_last_d;
   end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Register-file write-port scheduler: ALU/MEM arbitration, registered write stage,
// and a per-register busy scoreboard that gates issue on RAW/WAW hazards.
module rf_wb_scheduler #(
   parameter int ADDR_W = rf_ctrl_pkg::ADDR_W,
   parameter int DATA_W = rf_ctrl_pkg::DATA_W,
   parameter int NREG   = 2 ** ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              iss_valid,
   input  logic              iss_wr,
   input  logic [ADDR_W-1:0] iss_dst,
   input  logic [ADDR_W-1:0] iss_src1,
   input  logic [ADDR_W-1:0] iss_src2,
   output logic              iss_ready,
   input  logic              alu_valid,
   input  logic [ADDR_W-1:0] alu_addr,
   input  logic [DATA_W-1:0] alu_data,
   output logic              alu_ready,
   input  logic              mem_valid,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   output logic              mem_ready,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic [NREG-1:0]   busy,
   output logic              err_unres
);

   logic [NREG-1:0]   busy_q, busy_d;
   logic              rf_we_q, rf_we_d;
   logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
   logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
   logic              err_q, err_d;
   logic [1:0]        gnt;
   logic              iss_set;

   rr_arb2 u_arb (
      .clk   (clk),
      .reset (reset),
      .req_i ({mem_valid, alu_valid}),
      .gnt_o (gnt)
   );

   assign alu_ready = gnt[0];
   assign mem_ready = gnt[1];

   // Hazard check reads registered busy only; a commit frees its register one cycle later.
   assign iss_ready = !(busy_q[iss_src1] | busy_q[iss_src2] | (iss_wr & busy_q[iss_dst]));
   assign iss_set   = iss_valid & iss_ready & iss_wr;

   always_comb begin
      rf_we_d    = |gnt;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      if (gnt[1]) begin
         rf_waddr_d = mem_addr;
         rf_wdata_d = mem_data;
      end else if (gnt[0]) begin
         rf_waddr_d = alu_addr;
         rf_wdata_d = alu_data;
      end
   end

   // Clear on commit first so a same-edge set of the same register wins.
   always_comb begin
      busy_d = busy_q;
      if (rf_we_q) busy_d[rf_waddr_q] = 1'b0;
      if (iss_set) busy_d[iss_dst]    = 1'b1;
      err_d  = err_q | (rf_we_q & ~busy_q[rf_waddr_q]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q     <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         err_q      <= 1'b0;
      end else begin
         busy_q     <= busy_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         err_q      <= err_d;
      end
   end

   assign rf_we     = rf_we_q;
   assign rf_waddr  = rf_waddr_q;
   assign rf_wdata  = rf_wdata_q;
   assign busy      = busy_q;
   assign err_unres = err_q;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for rf_wb_scheduler with a write-port scoreboard.
module tb_rf_wb_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic        iss_valid, iss_wr;
   logic [2:0]  iss_dst, iss_src1, iss_src2;
   logic        iss_ready;
   logic        alu_valid, mem_valid, alu_ready, mem_ready;
   logic [2:0]  alu_addr, mem_addr;
   logic [15:0] alu_data, mem_data;
   logic        rf_we;
   logic [2:0]  rf_waddr;
   logic [15:0] rf_wdata;
   logic [7:0]  busy;
   logic        err_unres;

   int n_pass = 0;
   int n_fail = 0;
   logic [18:0] exp_q[$];

   always #5 clk = ~clk;

   rf_wb_scheduler dut (
      .clk(clk), .reset(reset),
      .iss_valid(iss_valid), .iss_wr(iss_wr), .iss_dst(iss_dst),
      .iss_src1(iss_src1), .iss_src2(iss_src2), .iss_ready(iss_ready),
      .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .busy(busy), .err_unres(err_unres)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] dst);
      iss_valid = 1'b1; iss_wr = 1'b1; iss_dst = dst; iss_src1 = 3'd0; iss_src2 = 3'd0;
      cyc();
      iss_valid = 1'b0; iss_wr = 1'b0;
   endtask

   // Every register-file write must match the oldest expected write.
   always @(negedge clk) begin
      if (!reset && rf_we) begin
         if (exp_q.size() == 0) chk("sb_unexpected_write", {13'd0, rf_waddr, rf_wdata}, 32'hFFFF_FFFF);
         else begin
            logic [18:0] e;
            e = exp_q.pop_front();
            chk("sb_write", {13'd0, rf_waddr, rf_wdata}, {13'd0, e});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      iss_valid = 0; iss_wr = 0; iss_dst = 0; iss_src1 = 0; iss_src2 = 0;
      alu_valid = 0; alu_addr = 0; alu_data = 0;
      mem_valid = 0; mem_addr = 0; mem_data = 0;
      repeat (2) cyc();
      reset = 1'b0;
      cyc();
      chk("rst_busy", busy, 8'h00);
      chk("rst_we", rf_we, 1'b0);
      chk("rst_waddr", rf_waddr, 3'd0);
      chk("rst_wdata", rf_wdata, 16'h0);
      chk("rst_err", err_unres, 1'b0);

      // single ALU write
      issue(3'd3);
      chk("single_busy_set", busy, 8'h08);
      alu_valid = 1; alu_addr = 3'd3; alu_data = 16'h1234;
      #1;
      chk("single_alu_rdy", alu_ready, 1'b1);
      chk("single_mem_rdy", mem_ready, 1'b0);
      exp_q.push_back({3'd3, 16'h1234});
      cyc();
      alu_valid = 0;
      chk("single_we", rf_we, 1'b1);
      chk("single_waddr", rf_waddr, 3'd3);
      chk("single_wdata", rf_wdata, 16'h1234);
      chk("single_busy_n1", busy, 8'h08);
      cyc();
      chk("single_busy_n2", busy, 8'h00);
      chk("single_we_idle", rf_we, 1'b0);
      chk("single_waddr_hold", rf_waddr, 3'd3);
      chk("single_wdata_hold", rf_wdata, 16'h1234);

      // first tie goes to MEM
      issue(3'd1);
      issue(3'd2);
      chk("tie_busy", busy, 8'h06);
      alu_valid = 1; alu_addr = 3'd1; alu_data = 16'hAAAA;
      mem_valid = 1; mem_addr = 3'd2; mem_data = 16'h5555;
      #1;
      chk("tie1_mem_rdy", mem_ready, 1'b1);
      chk("tie1_alu_rdy", alu_ready, 1'b0);
      exp_q.push_back({3'd2, 16'h5555});
      cyc();
      mem_valid = 0;
      #1;
      chk("tie1_alu_next", alu_ready, 1'b1);
      exp_q.push_back({3'd1, 16'hAAAA});
      chk("tie1_waddr_n1", rf_waddr, 3'd2);
      cyc();
      alu_valid = 0;
      chk("tie1_waddr_n2", rf_waddr, 3'd1);
      chk("tie1_wdata_n2", rf_wdata, 16'hAAAA);
      cyc();
      chk("tie1_busy_clr", busy, 8'h00);

      // second tie goes to ALU
      issue(3'd1);
      issue(3'd2);
      alu_valid = 1; alu_addr = 3'd1; alu_data = 16'hBEEF;
      mem_valid = 1; mem_addr = 3'd2; mem_data = 16'hCAFE;
      #1;
      chk("tie2_alu_rdy", alu_ready, 1'b1);
      chk("tie2_mem_rdy", mem_ready, 1'b0);
      exp_q.push_back({3'd1, 16'hBEEF});
      cyc();
      alu_valid = 0;
      #1;
      chk("tie2_mem_next", mem_ready, 1'b1);
      exp_q.push_back({3'd2, 16'hCAFE});
      cyc();
      mem_valid = 0;
      cyc();
      chk("tie2_busy_clr", busy, 8'h00);
      chk("tie2_err", err_unres, 1'b0);

      // RAW stall on r5
      issue(3'd5);
      iss_valid = 1; iss_wr = 0; iss_dst = 3'd0; iss_src1 = 3'd0; iss_src2 = 3'd5;
      alu_valid = 1; alu_addr = 3'd5; alu_data = 16'h0505;
      #1;
      chk("raw_stall_n", iss_ready, 1'b0);
      exp_q.push_back({3'd5, 16'h0505});
      cyc();
      alu_valid = 0;
      chk("raw_stall_n1", iss_ready, 1'b0);
      cyc();
      chk("raw_ready_n2", iss_ready, 1'b1);
      iss_valid = 0; iss_src2 = 3'd0;

      // WAW stall on r4
      issue(3'd4);
      iss_valid = 1; iss_wr = 1; iss_dst = 3'd4; iss_src1 = 3'd0; iss_src2 = 3'd0;
      #1;
      chk("waw_stall", iss_ready, 1'b0);
      iss_wr = 0;
      #1;
      chk("waw_nowr_ready", iss_ready, 1'b1);
      iss_valid = 0;
      mem_valid = 1; mem_addr = 3'd4; mem_data = 16'h4444;
      exp_q.push_back({3'd4, 16'h4444});
      cyc();
      mem_valid = 0;
      cyc();
      chk("waw_busy_clr", busy, 8'h00);

      // unreserved write to r6
      mem_valid = 1; mem_addr = 3'd6; mem_data = 16'h6666;
      #1;
      chk("unres_mem_rdy", mem_ready, 1'b1);
      exp_q.push_back({3'd6, 16'h6666});
      cyc();
      mem_valid = 0;
      chk("unres_we", rf_we, 1'b1);
      chk("unres_err_n1", err_unres, 1'b0);
      cyc();
      chk("unres_err_set", err_unres, 1'b1);
      repeat (2) cyc();
      chk("unres_err_sticky", err_unres, 1'b1);

      // reset mid-run with pending writers
      issue(3'd2);
      issue(3'd3);
      issue(3'd5);
      chk("midrst_busy_pre", busy, 8'h2C);
      reset = 1;
      repeat (2) cyc();
      reset = 0;
      chk("midrst_busy", busy, 8'h00);
      chk("midrst_we", rf_we, 1'b0);
      chk("midrst_err", err_unres, 1'b0);
      cyc();
      chk("postrst_busy", busy, 8'h00);
      chk("postrst_err", err_unres, 1'b0);

      repeat (2) cyc();
      chk("sb_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
      $finish;
   end

endmodule
